// File: rtl/register_read_pkg.sv
// Shared constants and write-back bundle helpers for the register read and write-back stages.
// The bundle layout here is the single source of truth for both sides of the register file.
package register_read_pkg;

  localparam int DW     = 64;
  localparam int AW     = 4;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 2;
  localparam int NREG   = 1 << AW;

  localparam int WB_ADDR_LSB = 0;
  localparam int WB_VAL_LSB  = 4;
  localparam int WB_WE_BIT   = 68;
  localparam int WB_W        = 69;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [WB_W-1:0] wb_t;

  function automatic wb_t wb_pack(input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] val);
    wb_t b;
    b                       = '0;
    b[WB_ADDR_LSB +: AW]    = addr;
    b[WB_VAL_LSB +: DW]     = val;
    b[WB_WE_BIT]            = we;
    return b;
  endfunction

  function automatic logic wb_is_write(input wb_t b);
    return b[WB_WE_BIT];
  endfunction

  function automatic logic [AW-1:0] wb_addr(input wb_t b);
    return b[WB_ADDR_LSB +: AW];
  endfunction

  function automatic logic [DW-1:0] wb_value(input wb_t b);
    return b[WB_VAL_LSB +: DW];
  endfunction

endpackage

// File: rtl/register_read_if.sv
// Decode-side, register-file, write-back and execute-side signals of the operand-fetch stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface register_read_if;
  import register_read_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_src1;
  logic [AW-1:0]     in_src2;
  logic              in_src1_use;
  logic              in_src2_use;
  logic [AW-1:0]     in_dst;
  logic              in_dst_we;
  logic [CTRL_W-1:0] in_ctrl;

  logic [AW-1:0]     rf_rd_addr1;
  logic [AW-1:0]     rf_rd_addr2;
  logic [DW-1:0]     rf_rd_data1;
  logic [DW-1:0]     rf_rd_data2;

  wb_t               wb_bundle;

  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_op1;
  logic [DW-1:0]     out_op2;
  logic [AW-1:0]     out_dst;
  logic              out_dst_we;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_src1, in_src2, in_src1_use, in_src2_use, in_dst, in_dst_we, in_ctrl,
    output in_ready,
    output rf_rd_addr1, rf_rd_addr2,
    input  rf_rd_data1, rf_rd_data2,
    input  wb_bundle,
    output out_valid, out_op1, out_op2, out_dst, out_dst_we, out_ctrl,
    input  out_ready
  );

  modport master (
    output in_valid, in_src1, in_src2, in_src1_use, in_src2_use, in_dst, in_dst_we, in_ctrl,
    input  in_ready,
    input  rf_rd_addr1, rf_rd_addr2,
    output rf_rd_data1, rf_rd_data2,
    output wb_bundle,
    input  out_valid, out_op1, out_op2, out_dst, out_dst_we, out_ctrl,
    output out_ready
  );
endinterface

// File: rtl/register_read_reg_scoreboard.sv
// Per-register pending-write counters: +1 on issue with a destination, -1 on write-back.
// Queries are combinational from current state; updates land on the next edge.
module reg_scoreboard
  import register_read_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [AW-1:0]    inc_addr,
  input  logic             dec,
  input  logic [AW-1:0]    dec_addr,
  input  logic [AW-1:0]    q1_addr,
  input  logic [AW-1:0]    q2_addr,
  input  logic [AW-1:0]    q3_addr,
  output logic [CNT_W-1:0] q1_cnt,
  output logic [CNT_W-1:0] q2_cnt,
  output logic [CNT_W-1:0] q3_cnt
);

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      logic inc_hit;
      logic dec_hit;
      inc_hit    = inc && (inc_addr == AW'(i));
      // A write-back to an idle register is spurious and must not wrap the counter.
      dec_hit    = dec && (dec_addr == AW'(i)) && (cnt[i] != '0);
      cnt_nxt[i] = cnt[i];
      if (inc_hit && !dec_hit)
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      else if (dec_hit && !inc_hit)
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign q1_cnt = cnt[q1_addr];
  assign q2_cnt = cnt[q2_addr];
  assign q3_cnt = cnt[q3_addr];

endmodule

// File: rtl/register_read.sv
// Operand fetch: reads two sources, forwards same-cycle write-back, stalls on RAW hazards.
// 1-cycle latency; output register holds while out_ready is low and in_ready drops with it.
module register_read
  import register_read_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  register_read_if.slave bus
);

  logic [CNT_W-1:0] cnt1, cnt2, cnt_dst;
  logic             wb_we;
  logic [AW-1:0]    wb_a;
  logic [DW-1:0]    wb_v;
  logic             ok1, ok2, hazard, slot_free, issue;
  logic             fwd1, fwd2;
  logic [DW-1:0]    op1, op2;

  assign wb_we = wb_is_write(bus.wb_bundle);
  assign wb_a  = wb_addr(bus.wb_bundle);
  assign wb_v  = wb_value(bus.wb_bundle);

  assign bus.rf_rd_addr1 = bus.in_src1;
  assign bus.rf_rd_addr2 = bus.in_src2;

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (issue && bus.in_dst_we),
    .inc_addr (bus.in_dst),
    .dec      (wb_we),
    .dec_addr (wb_a),
    .q1_addr  (bus.in_src1),
    .q2_addr  (bus.in_src2),
    .q3_addr  (bus.in_dst),
    .q1_cnt   (cnt1),
    .q2_cnt   (cnt2),
    .q3_cnt   (cnt_dst)
  );

  // Forward only when this write-back retires the last outstanding write to the source.
  assign fwd1 = wb_we && (wb_a == bus.in_src1) && (cnt1 == CNT_W'(1));
  assign fwd2 = wb_we && (wb_a == bus.in_src2) && (cnt2 == CNT_W'(1));

  assign ok1 = !bus.in_src1_use || (cnt1 == '0) || fwd1;
  assign ok2 = !bus.in_src2_use || (cnt2 == '0) || fwd2;

  assign hazard    = !ok1 || !ok2 || (bus.in_dst_we && (cnt_dst == CNT_MAX));
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = slot_free && !hazard;
  assign issue     = bus.in_valid && bus.in_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (bus.in_src1_use) op1 = fwd1 ? wb_v : bus.rf_rd_data1;
    if (bus.in_src2_use) op2 = fwd2 ? wb_v : bus.rf_rd_data2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_op1    <= '0;
      bus.out_op2    <= '0;
      bus.out_dst    <= '0;
      bus.out_dst_we <= 1'b0;
      bus.out_ctrl   <= '0;
    end else if (issue) begin
      bus.out_valid  <= 1'b1;
      bus.out_op1    <= op1;
      bus.out_op2    <= op2;
      bus.out_dst    <= bus.in_dst;
      bus.out_dst_we <= bus.in_dst_we;
      bus.out_ctrl   <= bus.in_ctrl;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

endmodule
